// File: rtl/dds_pkg.sv
// Shared types and widths for the DDS frequency-sweep controller.
package dds_pkg;

    localparam int DDS_FW = 12;
    localparam int BCD_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SETTLE,
        S_MEASURE,
        S_REPORT,
        S_NEXT,
        S_DONE
    } state_e;

endpackage

// File: rtl/dds_sweep_ctrl_sweep_timer.sv
// Down-counter shared by the settle wait and the measurement timeout.
// Expires on the last counted cycle after a load of N, i.e. N cycles of count.
module sweep_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_count,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_count && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (r_cnt <= W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Steps a DDS control word from start to stop, waits for the meter to settle,
// and reports one (control word, BCD reading) point per step.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FW          = DDS_FW,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [FW-1:0]    freq_start,
    input  logic [FW-1:0]    freq_stop,
    input  logic [FW-1:0]    freq_step,
    input  logic             meas_valid,
    input  logic [BCD_W-1:0] meas_bcd,
    output logic [FW-1:0]    freq_ctl,
    output logic             busy,
    output logic             point_valid,
    output logic [FW-1:0]    point_freq,
    output logic [BCD_W-1:0] point_bcd,
    output logic             done,
    output logic             err
);

    localparam int TMAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] SETTLE_LD  = TW'(SETTLE_CYC);
    localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT_CYC);

    state_e           r_state, w_next;
    logic [FW-1:0]    r_fstart, r_fstop, r_fstep;
    logic [FW-1:0]    r_freq_ctl, r_point_freq;
    logic [BCD_W-1:0] r_point_bcd;
    logic             r_busy, r_point_valid, r_done, r_err;

    logic             w_tmr_load, w_tmr_exp, w_tmr_count;
    logic [TW-1:0]    w_tmr_val;
    logic             w_latch, w_fail, w_first, w_capture, w_advance;
    logic             w_bad, w_at_stop;
    logic [FW:0]      w_sum;
    logic [FW-1:0]    w_step_freq;

    // One extra bit on the sum so a step past the top of the range clamps instead of wrapping.
    assign w_sum       = {1'b0, r_freq_ctl} + {1'b0, r_fstep};
    assign w_step_freq = (w_sum > {1'b0, r_fstop}) ? r_fstop : w_sum[FW-1:0];
    assign w_bad       = (r_fstep == '0) || (r_fstop < r_fstart);
    assign w_at_stop   = (r_freq_ctl == r_fstop);
    assign w_tmr_count = (r_state == S_SETTLE) || (r_state == S_MEASURE);

    sweep_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_count    (w_tmr_count),
        .o_expire   (w_tmr_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        w_latch    = 1'b0;
        w_fail     = 1'b0;
        w_first    = 1'b0;
        w_capture  = 1'b0;
        w_advance  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next  = S_CHECK;
                    w_latch = 1'b1;
                end
            end
            S_CHECK: begin
                if (w_bad) begin
                    w_next = S_IDLE;
                    w_fail = 1'b1;
                end else begin
                    w_next     = S_SETTLE;
                    w_first    = 1'b1;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = SETTLE_LD;
                end
            end
            S_SETTLE: begin
                // Meter pulses here belong to a gate window opened at the old frequency.
                if (w_tmr_exp) begin
                    w_next     = S_MEASURE;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TIMEOUT_LD;
                end
            end
            S_MEASURE: begin
                if (meas_valid) begin
                    w_next    = S_REPORT;
                    w_capture = 1'b1;
                end else if (w_tmr_exp) begin
                    w_next = S_IDLE;
                    w_fail = 1'b1;
                end
            end
            S_REPORT: begin
                w_next = S_NEXT;
            end
            S_NEXT: begin
                if (w_at_stop) begin
                    w_next = S_DONE;
                end else begin
                    w_next     = S_SETTLE;
                    w_advance  = 1'b1;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = SETTLE_LD;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Abort overrides every action, including a coincident capture or timeout.
        if (abort && (r_state != S_IDLE)) begin
            w_next     = S_IDLE;
            w_tmr_load = 1'b0;
            w_fail     = 1'b0;
            w_first    = 1'b0;
            w_capture  = 1'b0;
            w_advance  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fstart      <= '0;
            r_fstop       <= '0;
            r_fstep       <= '0;
            r_freq_ctl    <= '0;
            r_point_freq  <= '0;
            r_point_bcd   <= '0;
            r_busy        <= 1'b0;
            r_point_valid <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_point_valid <= w_capture;
            r_done        <= (w_next == S_DONE);
            if (w_latch) begin
                r_fstart <= freq_start;
                r_fstop  <= freq_stop;
                r_fstep  <= freq_step;
                r_err    <= 1'b0;
                r_busy   <= 1'b1;
            end else if ((w_next == S_IDLE) || (w_next == S_DONE)) begin
                r_busy <= 1'b0;
            end
            if (w_fail) begin
                r_err <= 1'b1;
            end
            if (w_first) begin
                r_freq_ctl <= r_fstart;
            end else if (w_advance) begin
                r_freq_ctl <= w_step_freq;
            end
            if (w_capture) begin
                r_point_freq <= r_freq_ctl;
                r_point_bcd  <= meas_bcd;
            end
        end
    end

    assign freq_ctl    = r_freq_ctl;
    assign busy        = r_busy;
    assign point_valid = r_point_valid;
    assign point_freq  = r_point_freq;
    assign point_bcd   = r_point_bcd;
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: time-scheduled reference model compared every cycle,
// directed sweeps with literal point lists, then randomized sweeps and aborts.
module tb_dds_sweep_ctrl;

    localparam int FW = 12;
    localparam int S  = 16;
    localparam int T  = 100;

    logic          clk = 1'b0;
    logic          rst, start, abort, meas_valid;
    logic [FW-1:0] freq_start, freq_stop, freq_step;
    logic [15:0]   meas_bcd;
    logic [FW-1:0] freq_ctl, point_freq;
    logic [15:0]   point_bcd;
    logic          busy, point_valid, done, err;

    dds_sweep_ctrl #(.FW(FW), .SETTLE_CYC(S), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .freq_start(freq_start), .freq_stop(freq_stop), .freq_step(freq_step),
        .meas_valid(meas_valid), .meas_bcd(meas_bcd),
        .freq_ctl(freq_ctl), .busy(busy), .point_valid(point_valid),
        .point_freq(point_freq), .point_bcd(point_bcd), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    int got_q[$];
    int gotb_q[$];

    // Reference model: sweep events scheduled by absolute edge number.
    longint e = 0;
    longint t_check = -1, t_open = -1, t_dead = -1, t_adv = -1, t_end = -1;
    bit m_run = 0, m_bad = 0;
    int m_pts[$];
    int m_idx = 0;
    logic [FW-1:0] m_fctl = '0, m_pfreq = '0;
    logic [15:0]   m_pbcd = '0;
    logic m_busy = 0, m_pv = 0, m_done = 0, m_err = 0;

    // Meter stimulus: 0 silent, 1 every 50 cycles, 2 random; manual pulses via man_req.
    int mmode = 0;
    int per = 0;
    int man_req = 0, man_ack = 0;
    logic [15:0] man_bcd = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures < 40)
                $display("FAIL %s edge=%0d got=%0d want=%0d", nm, e, act, exp);
        end
    endtask

    task automatic clr_t();
        t_check = -1; t_open = -1; t_dead = -1; t_adv = -1; t_end = -1;
    endtask

    task automatic model_step();
        int n, f;
        e++;
        m_pv = 0;
        m_done = 0;
        if (rst) begin
            m_run = 0; m_fctl = '0; m_busy = 0; m_pfreq = '0; m_pbcd = '0; m_err = 0;
            clr_t();
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_err = 0; m_busy = 1;
                clr_t();
                t_check = e + 1;
                m_bad = (freq_step == 0) || (freq_stop < freq_start);
                m_pts.delete();
                if (!m_bad) begin
                    n = (int'(freq_stop) - int'(freq_start) + int'(freq_step) - 1) / int'(freq_step) + 1;
                    for (int k = 0; k < n; k++) begin
                        f = int'(freq_start) + k * int'(freq_step);
                        m_pts.push_back((f > int'(freq_stop)) ? int'(freq_stop) : f);
                    end
                end
            end
        end else if (abort) begin
            m_run = 0; m_busy = 0;
            clr_t();
        end else if (e == t_check) begin
            if (m_bad) begin
                m_err = 1; m_busy = 0; m_run = 0;
            end else begin
                m_idx = 0;
                m_fctl = FW'(m_pts[0]);
                t_open = e + S + 1;
                t_dead = t_open + T - 1;
            end
        end else if (t_open >= 0 && e >= t_open && e <= t_dead && meas_valid) begin
            m_pv = 1; m_pfreq = m_fctl; m_pbcd = meas_bcd;
            t_open = -1; t_dead = -1; t_adv = e + 2;
        end else if (e == t_dead) begin
            m_err = 1; m_busy = 0; m_run = 0;
        end else if (e == t_adv) begin
            if (m_idx == m_pts.size() - 1) begin
                m_done = 1; m_busy = 0; t_end = e + 1;
            end else begin
                m_idx++;
                m_fctl = FW'(m_pts[m_idx]);
                t_open = e + S + 1;
                t_dead = t_open + T - 1;
            end
        end else if (e == t_end) begin
            m_run = 0;
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        model_step();
        chk("freq_ctl", 32'(freq_ctl), 32'(m_fctl));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("point_valid", 32'(point_valid), 32'(m_pv));
        chk("point_freq", 32'(point_freq), 32'(m_pfreq));
        chk("point_bcd", 32'(point_bcd), 32'(m_pbcd));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
        if (point_valid === 1'b1) begin
            got_q.push_back(int'(point_freq));
            gotb_q.push_back(int'(point_bcd));
        end
        if (done === 1'b1) done_seen++;
    end

    function automatic logic [15:0] rand_bcd();
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    always begin
        @(negedge clk);
        meas_valid = 1'b0;
        case (mmode)
            1: begin
                per++;
                if (per >= 50) begin
                    per = 0;
                    meas_valid = 1'b1;
                    meas_bcd = rand_bcd();
                end
            end
            2: begin
                if ($urandom_range(0, 15) == 0) begin
                    meas_valid = 1'b1;
                    meas_bcd = rand_bcd();
                end
            end
            default: ;
        endcase
        if (man_req != man_ack) begin
            man_ack = man_req;
            meas_valid = 1'b1;
            meas_bcd = man_bcd;
        end
    end

    task automatic do_start(input int fs, input int fp, input int st);
        @(negedge clk);
        freq_start = FW'(fs);
        freq_stop  = FW'(fp);
        freq_step  = FW'(st);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!m_run && busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
        chk({nm, "_ends"}, 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    task automatic chk_pts(input string nm, input int exp[$]);
        chk({nm, "_npts"}, 32'(got_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got_q.size(); i++)
            chk({nm, "_pt"}, 32'(got_q[i]), 32'(exp[i]));
    endtask

    task automatic sweep(input string nm, input int fs, input int fp, input int st, input int exp[$]);
        int d0;
        got_q.delete();
        gotb_q.delete();
        d0 = done_seen;
        do_start(fs, fp, st);
        wait_idle(nm, 2000);
        chk_pts(nm, exp);
        chk({nm, "_done"}, 32'(done_seen - d0), 32'd1);
        chk({nm, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog edge=%0d got=running want=finished", e);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_q[$];
        int fs, fp, st, span, d0;
        bit ok;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        freq_start = '0; freq_stop = '0; freq_step = '0;
        meas_valid = 1'b0; meas_bcd = '0;
        repeat (3) @(negedge clk);
        chk("rst_freq_ctl", 32'(freq_ctl), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_pv", 32'(point_valid), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed sweeps with hand-derived point lists.
        mmode = 1;
        exp_q = '{100, 110, 120, 130};
        sweep("sw_even", 100, 130, 10, exp_q);
        exp_q = '{100, 110, 120, 125};
        sweep("sw_clamp", 100, 125, 10, exp_q);
        exp_q = '{4090, 4095};
        sweep("sw_nowrap", 4090, 4095, 8, exp_q);
        exp_q = '{777};
        sweep("sw_single", 777, 777, 5, exp_q);
        chk("fctl_hold", 32'(freq_ctl), 32'd777);

        // Bad bounds: err two edges after start.
        got_q.delete();
        do_start(100, 200, 0);
        @(negedge clk);
        chk("step0_err", 32'(err), 32'd1);
        chk("step0_busy", 32'(busy), 32'd0);
        wait_idle("step0", 10);
        do_start(200, 100, 5);
        chk("rev_err_cleared", 32'(err), 32'd0);
        @(negedge clk);
        chk("rev_err", 32'(err), 32'd1);
        chk("rev_busy", 32'(busy), 32'd0);
        wait_idle("rev", 10);
        chk("bad_npts", 32'(got_q.size()), 32'd0);

        // Silent meter: timeout.
        mmode = 0;
        got_q.delete();
        do_start(10, 10, 1);
        wait_idle("tmo", 400);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_npts", 32'(got_q.size()), 32'd0);

        // Pulse during settle is dropped, the next one is captured.
        got_q.delete();
        gotb_q.delete();
        do_start(50, 50, 1);
        repeat (4) @(negedge clk);
        man_bcd = 16'h1111;
        man_req++;
        repeat (16) @(negedge clk);
        man_bcd = 16'h2222;
        man_req++;
        wait_idle("stale", 300);
        chk("stale_npts", 32'(gotb_q.size()), 32'd1);
        if (gotb_q.size() > 0) chk("stale_bcd", 32'(gotb_q[0]), 32'h2222);

        // Abort during the second point.
        mmode = 1;
        per = 0;
        got_q.delete();
        d0 = done_seen;
        do_start(0, 100, 10);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (got_q.size() >= 1) begin
                ok = 1;
                break;
            end
        end
        chk("abort_first_pt", 32'(ok), 32'd1);
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (80) @(negedge clk);
        chk("abort_npts", 32'(got_q.size()), 32'd1);
        chk("abort_done", 32'(done_seen - d0), 32'd0);
        chk("abort_err", 32'(err), 32'd0);

        // Randomized sweeps with random meter timing and occasional aborts.
        mmode = 2;
        for (int n = 0; n < 25; n++) begin
            fs = $urandom_range(0, 4095);
            span = $urandom_range(0, 300);
            fp = (fs + span > 4095) ? 4095 : fs + span;
            st = $urandom_range(span / 8 + 1, span + 20);
            if ($urandom_range(0, 9) == 0) st = 0;
            if ($urandom_range(0, 9) == 0) begin
                int tmp;
                tmp = fs; fs = fp; fp = tmp;
            end
            do_start(fs, fp, st);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(0, 60)) @(negedge clk);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
            end
            wait_idle("rnd", 3000);
        end

        // Async reset mid-measure.
        mmode = 0;
        d0 = done_seen;
        do_start(300, 400, 50);
        repeat (S + 5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_freq_ctl", 32'(freq_ctl), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_pv", 32'(point_valid), 32'd0);
        chk("arst_pfreq", 32'(point_freq), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("arst_done", 32'(done_seen - d0), 32'd0);
        chk("arst_busy_after", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
